// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between NREQ
// requesters. One operation in flight; operands, result and flags registered.
module alu_arbiter #(
   parameter int BUS  = 8,
   parameter int NREQ = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]     req_valid_i,
   output logic [NREQ-1:0]     req_ready_o,
   input  logic [NREQ*BUS-1:0] req_a_i,
   input  logic [NREQ*BUS-1:0] req_b_i,
   input  logic [NREQ*3-1:0]   req_op_i,
   output logic [NREQ-1:0]     rsp_valid_o,
   input  logic [NREQ-1:0]     rsp_ready_i,
   output logic [BUS-1:0]      rsp_result_o,
   output logic [3:0]          rsp_flags_o,
   output logic [BUS-1:0]      alu_a_o,
   output logic [BUS-1:0]      alu_b_o,
   output logic [2:0]          alu_op_o,
   input  logic [BUS-1:0]      alu_result_i,
   input  logic [3:0]          alu_flags_i,
   output logic [1:0]          grant_o,
   output logic                busy_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   rr_ptr_reg;
   logic [IW-1:0]   grant_reg;
   logic [IW-1:0]   pick;
   logic            any_valid;
   logic            accept;
   logic            rsp_done;
   logic [BUS-1:0]  a_reg, b_reg, result_reg;
   logic [2:0]      op_reg;
   logic [3:0]      flags_reg;

   logic [BUS-1:0]  a_arr  [NREQ];
   logic [BUS-1:0]  b_arr  [NREQ];
   logic [2:0]      op_arr [NREQ];

   // Unpack the per-requester command buses and build the one-hot handshakes.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign a_arr[gi]       = req_a_i[gi*BUS +: BUS];
         assign b_arr[gi]       = req_b_i[gi*BUS +: BUS];
         assign op_arr[gi]      = req_op_i[gi*3 +: 3];
         assign req_ready_o[gi] = accept && (pick == IW'(gi));
         assign rsp_valid_o[gi] = (state_reg == RESP) && (grant_reg == IW'(gi));
      end
   endgenerate

   // Round-robin pick: first pass looks at indices at or above the pointer,
   // second pass wraps around to the lower indices.
   always_comb begin
      any_valid = 1'b0;
      pick      = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!any_valid && req_valid_i[j] && (IW'(j) >= rr_ptr_reg)) begin
            any_valid = 1'b1;
            pick      = IW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!any_valid && req_valid_i[j]) begin
            any_valid = 1'b1;
            pick      = IW'(j);
         end
      end
   end

   // Accept is gated by reset so no ready pulse escapes while reset is held.
   assign accept   = (state_reg == IDLE) && any_valid && !rst_i;
   assign rsp_done = (state_reg == RESP) && rsp_ready_i[grant_reg];

   // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Datapath: operand latch on accept, ALU capture in EXEC, pointer advance on response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_reg <= '0;
         grant_reg  <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         result_reg <= '0;
         flags_reg  <= '0;
      end else begin
         if (accept) begin
            a_reg     <= a_arr[pick];
            b_reg     <= b_arr[pick];
            op_reg    <= op_arr[pick];
            grant_reg <= pick;
         end
         if (state_reg == EXEC) begin
            result_reg <= alu_result_i;
            flags_reg  <= alu_flags_i;
         end
         if (rsp_done) begin
            rr_ptr_reg <= (grant_reg == IW'(NREQ-1)) ? '0 : grant_reg + IW'(1);
         end
      end
   end

   assign alu_a_o      = a_reg;
   assign alu_b_o      = b_reg;
   assign alu_op_o     = op_reg;
   assign rsp_result_o = result_reg;
   assign rsp_flags_o  = flags_reg;
   assign grant_o      = 2'(grant_reg);
   assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives the ALU ports,
// and a round-robin pointer model predicts grants.
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int BUS  = 8;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [NREQ-1:0]   req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
   logic [NREQ*BUS-1:0] req_a_i, req_b_i;
   logic [NREQ*3-1:0] req_op_i;
   logic [BUS-1:0]    rsp_result_o, alu_a_o, alu_b_o, alu_result_i;
   logic [3:0]        rsp_flags_o, alu_flags_i;
   logic [2:0]        alu_op_o;
   logic [1:0]        grant_o;
   logic              busy_o;

   int total = 0;
   int bad   = 0;
   int rr_model = 0;

   always #5 clk_i = ~clk_i;

   // Reference ALU: returns {V,C,N,Z,result}.
   function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
      logic [8:0] w;
      logic [7:0] r;
      logic v, c;
      v = 1'b0;
      c = 1'b0;
      w = '0;
      case (op)
         3'b000: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[7:0];
            c = w[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         3'b001: begin
            r = a - b;
            c = (a >= b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         3'b010:  r = a & b;
         3'b011:  r = a ^ b;
         3'b100:  r = ~a;
         3'b101:  r = b;
         3'b110:  r = a | b;
         default: r = a & ~b;
      endcase
      return {v, c, r[7], (r == 8'h00), r};
   endfunction

   assign {alu_flags_i, alu_result_i} = alu_fn(alu_a_o, alu_b_o, alu_op_o);

   // Round-robin expectation: first valid index at or after the pointer, modulo NREQ.
   function automatic int model_grant(input logic [NREQ-1:0] mask, input int ptr);
      int k;
      for (int i = 0; i < NREQ; i++) begin
         k = (ptr + i) % NREQ;
         if (mask[k]) return k;
      end
      return -1;
   endfunction

   alu_arbiter #(.BUS(BUS), .NREQ(NREQ)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
      .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   // Drives one command set starting at the current negedge, waits for the accept
   // and the response, then completes the response handshake. Returns observations.
   task automatic transact(input logic [1:0] mask,
                           input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                           input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                           input bit keep,
                           output int g, output int lat, output logic [1:0] rdy,
                           output logic [1:0] rv, output logic [7:0] res,
                           output logic [3:0] fl, output bit to);
      int n;
      g = -1; lat = -1; rdy = '0; rv = '0; res = '0; fl = '0; to = 1'b0;
      req_valid_i = mask;
      req_a_i     = {a1, a0};
      req_b_i     = {b1, b0};
      req_op_i    = {op1, op0};
      rsp_ready_i = '0;
      #1;
      n = 0;
      while (req_ready_o == '0 && n < 20) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      if (req_ready_o == '0) begin
         to = 1'b1;
         req_valid_i = '0;
         return;
      end
      rdy = req_ready_o;
      g   = rdy[1] ? 1 : 0;
      n   = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (rsp_valid_o == '0 && n < 20);
      if (rsp_valid_o == '0) begin
         to = 1'b1;
         req_valid_i = '0;
         return;
      end
      lat = n; rv = rsp_valid_o; res = rsp_result_o; fl = rsp_flags_o;
      rsp_ready_i = rv;
      @(negedge clk_i);
      rsp_ready_i = '0;
      if (!keep) req_valid_i = '0;
      $display("txn mask=%b grant=%0d lat=%0d rsp_valid=%b result=%h flags=%b",
               mask, g, lat, rv, res, fl);
   endtask

   task automatic test_reset();
      rst_i = 1'b1; req_valid_i = '0; rsp_ready_i = '0;
      req_a_i = '0; req_b_i = '0; req_op_i = '0;
      repeat (2) @(negedge clk_i);
      req_valid_i = 2'b11;
      #1;
      total++;
      if ({req_ready_o, rsp_valid_o, grant_o, busy_o} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl got rdy=%b vld=%b grant=%0d busy=%b want all 0",
                  req_ready_o, rsp_valid_o, grant_o, busy_o);
      end
      total++;
      if ({alu_a_o, alu_b_o, alu_op_o, rsp_result_o, rsp_flags_o} !== 31'b0) begin
         bad++;
         $display("FAIL reset_data got a=%h b=%h op=%b res=%h fl=%b want all 0",
                  alu_a_o, alu_b_o, alu_op_o, rsp_result_o, rsp_flags_o);
      end
      req_valid_i = '0;
      @(negedge clk_i);
      rst_i = 1'b0;
      rr_model = 0;
   endtask

   task automatic test_add_overflow();
      int g, lat; logic [1:0] rdy, rv; logic [7:0] res; logic [3:0] fl; bit to;
      transact(2'b01, 8'h7F, 8'h01, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0,
               g, lat, rdy, rv, res, fl, to);
      total++;
      if (to) begin
         bad++; $display("FAIL t1_timeout got no handshake want accept+response");
      end else begin
         if (g !== 0 || rdy !== 2'b01) begin
            bad++; $display("FAIL t1_accept got grant=%0d rdy=%b want 0/01", g, rdy);
         end
         total++;
         if (lat !== 2 || rv !== 2'b01) begin
            bad++; $display("FAIL t1_latency got lat=%0d vld=%b want 2/01", lat, rv);
         end
         total++;
         if (res !== 8'h80 || fl !== 4'b1010) begin
            bad++; $display("FAIL t1_data got res=%h fl=%b want 80/1010", res, fl);
         end
         total++;
         if (rsp_result_o !== 8'h80 || busy_o !== 1'b0) begin
            bad++; $display("FAIL t1_hold got res=%h busy=%b want 80/0", rsp_result_o, busy_o);
         end
      end
      rr_model = 1;
   endtask

   task automatic test_sub_zero();
      int g, lat; logic [1:0] rdy, rv; logic [7:0] res; logic [3:0] fl; bit to;
      transact(2'b10, 8'h00, 8'h00, 3'b000, 8'h05, 8'h05, 3'b001, 1'b0,
               g, lat, rdy, rv, res, fl, to);
      total++;
      if (to) begin
         bad++; $display("FAIL t2_timeout got no handshake want accept+response");
      end else begin
         if (g !== 1 || rv !== 2'b10) begin
            bad++; $display("FAIL t2_grant got grant=%0d vld=%b want 1/10", g, rv);
         end
         total++;
         if (res !== 8'h00 || fl !== 4'b0101) begin
            bad++; $display("FAIL t2_data got res=%h fl=%b want 00/0101", res, fl);
         end
      end
      rr_model = 0;
   endtask

   task automatic test_or();
      int g, lat; logic [1:0] rdy, rv; logic [7:0] res; logic [3:0] fl; bit to;
      transact(2'b01, 8'h00, 8'h00, 3'b110, 8'h00, 8'h00, 3'b000, 1'b0,
               g, lat, rdy, rv, res, fl, to);
      total++;
      if (to || res !== 8'h00 || fl !== 4'b0001) begin
         bad++; $display("FAIL t3_or_zero got to=%0d res=%h fl=%b want 00/0001", to, res, fl);
      end
      transact(2'b10, 8'h00, 8'h00, 3'b000, 8'hF0, 8'h0F, 3'b110, 1'b0,
               g, lat, rdy, rv, res, fl, to);
      total++;
      if (to || res !== 8'hFF || fl !== 4'b0010) begin
         bad++; $display("FAIL t3_or_ff got to=%0d res=%h fl=%b want ff/0010", to, res, fl);
      end
      rr_model = 0;
   endtask

   task automatic test_round_robin();
      int g, lat; logic [1:0] rdy, rv; logic [7:0] res; logic [3:0] fl; bit to;
      logic [7:0] a0, b0, a1, b1; logic [2:0] op0, op1;
      logic [11:0] e;
      a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom);
      for (int i = 0; i < 4; i++) begin
         transact(2'b11, a0, b0, op0, a1, b1, op1, (i < 3),
                  g, lat, rdy, rv, res, fl, to);
         e = (i % 2 == 0) ? alu_fn(a0, b0, op0) : alu_fn(a1, b1, op1);
         total++;
         if (to || g !== (i % 2)) begin
            bad++; $display("FAIL t4_grant%0d got grant=%0d to=%0d want %0d", i, g, to, i % 2);
         end
         total++;
         if ({fl, res} !== e) begin
            bad++; $display("FAIL t4_data%0d got %h want %h", i, {fl, res}, e);
         end
         if (g >= 0) rr_model = (g + 1) % NREQ;
      end
   endtask

   task automatic test_backpressure();
      int n, g, eg; logic [11:0] e;
      logic [7:0] a0, b0, a1, b1; logic [2:0] op0, op1;
      a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom);
      req_valid_i = 2'b11; req_a_i = {a1, a0}; req_b_i = {b1, b0}; req_op_i = {op1, op0};
      rsp_ready_i = '0;
      eg = model_grant(2'b11, rr_model);
      #1;
      n = 0;
      while (req_ready_o == '0 && n < 20) begin
         @(negedge clk_i); #1; n++;
      end
      total++;
      if (req_ready_o !== (2'b01 << eg)) begin
         bad++; $display("FAIL t5_accept got rdy=%b want %b", req_ready_o, 2'b01 << eg);
      end
      g = eg;
      e = (g == 0) ? alu_fn(a0, b0, op0) : alu_fn(a1, b1, op1);
      repeat (2) @(negedge clk_i);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (rsp_valid_o !== (2'b01 << g) || {rsp_flags_o, rsp_result_o} !== e ||
             req_ready_o !== 2'b00) begin
            bad++;
            $display("FAIL t5_stall%0d got vld=%b data=%h rdy=%b want %b/%h/00",
                     c, rsp_valid_o, {rsp_flags_o, rsp_result_o}, req_ready_o, 2'b01 << g, e);
         end
         if (c == 3) rsp_ready_i = ~(2'b01 << g);
         @(negedge clk_i);
      end
      total++;
      if (busy_o !== 1'b1 || rsp_valid_o !== (2'b01 << g)) begin
         bad++; $display("FAIL t5_other_ready got busy=%b vld=%b want 1/%b",
                         busy_o, rsp_valid_o, 2'b01 << g);
      end
      rsp_ready_i = 2'b01 << g;
      @(negedge clk_i);
      total++;
      if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00) begin
         bad++; $display("FAIL t5_release got busy=%b vld=%b want 0/00", busy_o, rsp_valid_o);
      end
      req_valid_i = '0; rsp_ready_i = '0;
      $display("txn backpressure grant=%0d data=%h", g, {rsp_flags_o, rsp_result_o});
      rr_model = (g + 1) % NREQ;
   endtask

   task automatic test_random();
      int g, lat, eg; logic [1:0] rdy, rv; logic [7:0] res; logic [3:0] fl; bit to;
      logic [1:0] mask; logic [7:0] a0, b0, a1, b1; logic [2:0] op0, op1;
      logic [11:0] e;
      for (int i = 0; i < 12; i++) begin
         mask = 2'($urandom_range(1, 3));
         a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
         a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom);
         eg = model_grant(mask, rr_model);
         e  = (eg == 0) ? alu_fn(a0, b0, op0) : alu_fn(a1, b1, op1);
         transact(mask, a0, b0, op0, a1, b1, op1, 1'b0, g, lat, rdy, rv, res, fl, to);
         total++;
         if (to || g !== eg || rdy !== (2'b01 << eg) || rv !== (2'b01 << eg) || lat !== 2) begin
            bad++;
            $display("FAIL rnd%0d_ctrl got to=%0d grant=%0d rdy=%b vld=%b lat=%0d want grant=%0d lat=2",
                     i, to, g, rdy, rv, lat, eg);
         end
         total++;
         if ({fl, res} !== e) begin
            bad++; $display("FAIL rnd%0d_data got %h want %h", i, {fl, res}, e);
         end
         rr_model = (eg + 1) % NREQ;
      end
   endtask

   task automatic test_reset_mid_op();
      int g, lat, n; logic [1:0] rdy, rv; logic [7:0] res; logic [3:0] fl; bit to;
      transact(2'b01, 8'h11, 8'h22, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0,
               g, lat, rdy, rv, res, fl, to);
      rr_model = 1;
      req_valid_i = 2'b11; req_a_i = 16'h3344; req_b_i = 16'h5566; req_op_i = 6'b000_000;
      #1;
      n = 0;
      while (req_ready_o == '0 && n < 20) begin
         @(negedge clk_i); #1; n++;
      end
      @(negedge clk_i);
      total++;
      if (busy_o !== 1'b1 || grant_o !== 2'd1) begin
         bad++; $display("FAIL t6_in_exec got busy=%b grant=%0d want 1/1", busy_o, grant_o);
      end
      rst_i = 1'b1;
      #1;
      total++;
      if ({req_ready_o, rsp_valid_o, grant_o, busy_o, alu_a_o, alu_b_o, alu_op_o,
           rsp_result_o, rsp_flags_o} !== 38'b0) begin
         bad++;
         $display("FAIL t6_async got rdy=%b vld=%b grant=%0d busy=%b a=%h res=%h want all 0",
                  req_ready_o, rsp_valid_o, grant_o, busy_o, alu_a_o, rsp_result_o);
      end
      req_valid_i = '0;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         total++;
         if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
            bad++; $display("FAIL t6_no_rsp%0d got vld=%b busy=%b want 00/0", c, rsp_valid_o, busy_o);
         end
      end
      rr_model = 0;
      transact(2'b11, 8'h0A, 8'h03, 3'b001, 8'h0B, 8'h04, 3'b000, 1'b0,
               g, lat, rdy, rv, res, fl, to);
      total++;
      if (to || g !== 0 || res !== 8'h07) begin
         bad++; $display("FAIL t6_regrant got to=%0d grant=%0d res=%h want 0/07", to, g, res);
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_zero();
      test_or();
      test_round_robin();
      test_backpressure();
      test_random();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
